// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_stream_pkg;

  localparam int BUF_DEPTH      = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } rd_state_t;

  // Buffer slots already claimed: words held plus the word still on its way from the FIFO.
  function automatic logic [2:0] slots_claimed(input logic [1:0] occ, input logic inflight);
    return {1'b0, occ} + {2'b00, inflight};
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream; master is the reader side.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  Read_enable;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  empty, data_out, m_ready,
    output Read_enable, m_valid, m_data
  );

  modport slave (
    output empty, data_out, m_ready,
    input  Read_enable, m_valid, m_data
  );
endinterface

// File: rtl/fifo_stream_skid_buf.sv
// Two-entry in-order output buffer; slot0 is always the head, clear outranks push/pop.
module fifo_stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] slot0_r, slot1_r;
  logic [DATA_WIDTH-1:0] slot0_nxt_s, slot1_nxt_s;
  logic [1:0]            occ_r, occ_nxt_s;

  // Next buffer contents for push, pop, simultaneous push+pop, or clear.
  always_comb begin
    slot0_nxt_s = slot0_r;
    slot1_nxt_s = slot1_r;
    occ_nxt_s   = occ_r;
    if (clear) begin
      occ_nxt_s = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          occ_nxt_s = occ_r + 2'd1;
          if (occ_r == 2'd0) begin
            slot0_nxt_s = push_data;
          end else begin
            slot1_nxt_s = push_data;
          end
        end
        2'b01: begin
          occ_nxt_s   = occ_r - 2'd1;
          slot0_nxt_s = slot1_r;
        end
        2'b11: begin
          // Head leaves while the new word joins the tail; occupancy is unchanged.
          if (occ_r == 2'd1) begin
            slot0_nxt_s = push_data;
          end else begin
            slot0_nxt_s = slot1_r;
            slot1_nxt_s = push_data;
          end
        end
        default: begin
          occ_nxt_s = occ_r;
        end
      endcase
    end
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_r <= {DATA_WIDTH{1'b0}};
      slot1_r <= {DATA_WIDTH{1'b0}};
      occ_r   <= 2'd0;
    end else begin
      slot0_r <= slot0_nxt_s;
      slot1_r <= slot1_nxt_s;
      occ_r   <= occ_nxt_s;
    end
  end

  assign occ       = occ_r;
  assign head_data = slot0_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read-side master presenting words on a valid/ready stream, with flush.
// Optional word counter output enabled by defining FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = fifo_stream_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_stream_pkg::DEF_ADDR_WIDTH,
  parameter int BUF_DEPTH  = fifo_stream_pkg::BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_stream_reader_if.master bus,
  input  logic                 flush,
  output logic                 busy,
  output logic                 flush_done
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [ADDR_WIDTH:0]  word_cnt
`endif
);
  import fifo_stream_pkg::*;

  if (BUF_DEPTH != 2 || ADDR_WIDTH < 1) begin : g_cfg_check
    $error("fifo_stream_reader: only BUF_DEPTH=2 and ADDR_WIDTH>=1 are supported");
  end

  rd_state_t             state_r, state_nxt_s;
  logic                  inflight_r;
  logic                  read_en_s, push_s, clear_s, flush_done_s;
  logic                  m_valid_s, pop_s;
  logic [1:0]            occ_s;
  logic [DATA_WIDTH-1:0] head_s;

  assign m_valid_s = (occ_s != 2'd0);
  // A word presented in the flush cycle is dropped, never handed over.
  assign pop_s     = m_valid_s && bus.m_ready && (state_r == STREAM) && !flush;

  // Next state, read issue and buffer control.
  always_comb begin
    state_nxt_s  = state_r;
    read_en_s    = 1'b0;
    push_s       = 1'b0;
    clear_s      = 1'b0;
    flush_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_nxt_s = FLUSH;
          clear_s     = 1'b1;
        end else if (!bus.empty) begin
          state_nxt_s = STREAM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      STREAM: begin
        push_s    = inflight_r;
        read_en_s = !bus.empty &&
                    (slots_claimed(occ_s, inflight_r) < (3'(BUF_DEPTH) + {2'b00, pop_s}));
        if (flush) begin
          state_nxt_s = FLUSH;
          clear_s     = 1'b1;
        end else if (bus.empty && (occ_s == 2'd0) && !inflight_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STREAM;
        end
      end
      FLUSH: begin
        read_en_s = !bus.empty;
        clear_s   = 1'b1;
        if (bus.empty && !inflight_r) begin
          state_nxt_s  = IDLE;
          flush_done_s = 1'b1;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        clear_s     = 1'b1;
      end
    endcase
  end

  // State register and outstanding-read tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= read_en_s;
    end
  end

  fifo_stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (bus.data_out),
    .pop       (pop_s),
    .occ       (occ_s),
    .head_data (head_s)
  );

  assign bus.Read_enable = read_en_s;
  assign bus.m_valid     = m_valid_s;
  assign bus.m_data      = head_s;
  assign busy            = (state_r != IDLE);
  assign flush_done      = flush_done_s;

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [ADDR_WIDTH:0] word_cnt_r;

  // Delivered-word counter; wraps naturally and survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt_r <= {(ADDR_WIDTH + 1){1'b0}};
    end else if (pop_s) begin
      word_cnt_r <= word_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  assign word_cnt = word_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: queue-based FIFO model feeding the reader, stream scoreboard on the output.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset, flush, busy, flush_done;
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [AW:0] word_cnt;
`endif

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BUF_DEPTH  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .flush      (flush),
    .busy       (busy),
    .flush_done (flush_done)
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    .word_cnt   (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int n_cmp = 0, n_err = 0;
  int n_re, n_hs, n_fd, hs_total, cyc, first_valid, last_hs;
  logic stall_prev;
  logic [DW-1:0] data_prev, first_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    bus.empty = 1'b0;
  endtask

  // Observe one cycle at the falling edge, then advance to just after the rising edge.
  task automatic step();
    logic re, rst, fl;
    @(negedge clk);
    re  = bus.Read_enable;
    rst = reset;
    fl  = flush;
    if (re) begin
      n_re++;
      chk("re_while_empty", {31'd0, bus.empty}, 32'd0);
    end
    if (stall_prev) begin
      chk("hold_valid", {31'd0, bus.m_valid}, 32'd1);
      chk("hold_data", {24'd0, bus.m_data}, {24'd0, data_prev});
    end
    if (bus.m_valid && first_valid < 0) first_valid = cyc;
    if (bus.m_valid && bus.m_ready && !fl && !rst) begin
      if (exp_q.size() == 0) chk("unexpected_word", {24'd0, bus.m_data}, 32'hFFFF_FFFF);
      else chk("order", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
      n_hs++;
      hs_total++;
      last_hs = cyc;
    end
    if (flush_done) n_fd++;
    stall_prev = bus.m_valid && !bus.m_ready && !fl && !rst;
    data_prev  = bus.m_data;
    if (fl) exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    if (re && fifo_q.size() > 0) bus.data_out = fifo_q.pop_front();
    bus.empty = (fifo_q.size() == 0);
    if (rst) begin
      exp_q      = fifo_q;
      hs_total   = 0;
      stall_prev = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int i = 0;
    bus.m_ready = 1'b1;
    while (i < budget && !(exp_q.size() == 0 && fifo_q.size() == 0 && !busy)) begin
      step();
      i++;
    end
    chk({tag, "_done"}, {31'd0, (exp_q.size() == 0 && fifo_q.size() == 0 && !busy)}, 32'd1);
  endtask

  task automatic clr_counts();
    n_re = 0; n_hs = 0; n_fd = 0; first_valid = -1; last_hs = -1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef FIFO_STREAM_READER_CNT_EN
    chk(tag, {26'd0, word_cnt}, hs_total % (1 << (AW + 1)));
`else
    chk(tag, {31'd0, busy}, 32'd0);
`endif
  endtask

  initial begin
    int i;
    reset = 1'b1; flush = 1'b0;
    bus.m_ready = 1'b0; bus.empty = 1'b1; bus.data_out = '0;
    cyc = 0; hs_total = 0; stall_prev = 1'b0; data_prev = '0;
    clr_counts();
    repeat (3) step();
    chk("rst_re", {31'd0, bus.Read_enable}, 32'd0);
    chk("rst_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.m_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fdone", {31'd0, flush_done}, 32'd0);
    reset = 1'b0;
    step();

    // basic order
    clr_counts();
    push(8'h11); push(8'h22); push(8'h33);
    drain("basic", 40);
    chk("basic_re", n_re, 3);
    chk("basic_hs", n_hs, 3);
    chk("basic_consec", last_hs - first_valid + 1, 3);
    chk("basic_busy", {31'd0, busy}, 32'd0);

    // full-rate throughput
    clr_counts();
    for (int k = 0; k < 32; k++) push(k[DW-1:0]);
    drain("thru", 80);
    chk("thru_hs", n_hs, 32);
    chk("thru_consec", last_hs - first_valid + 1, 32);
    chk_cnt("cnt_after_thru");

    // backpressure
    clr_counts();
    bus.m_ready = 1'b0;
    first_word = DW'($urandom);
    push(first_word);
    for (int k = 0; k < 4; k++) push(DW'($urandom));
    repeat (10) step();
    chk("bp_re", n_re, 2);
    chk("bp_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("bp_data", {24'd0, bus.m_data}, {24'd0, first_word});
    drain("bp", 40);
    chk("bp_hs", n_hs, 5);

    // alternating ready
    clr_counts();
    for (int k = 0; k < 8; k++) push(8'hA0 + k[DW-1:0]);
    for (int k = 0; k < 40; k++) begin
      bus.m_ready = k[0];
      step();
    end
    chk("alt_hs", n_hs, 8);
    chk("alt_left", exp_q.size(), 0);
    drain("alt", 20);

    // flush after two accepted words
    clr_counts();
    bus.m_ready = 1'b1;
    for (int k = 0; k < 10; k++) push(8'hC0 + k[DW-1:0]);
    i = 0;
    while (i < 40 && n_hs < 2) begin step(); i++; end
    chk("fl_accept2", n_hs, 2);
    bus.m_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid_drop", {31'd0, bus.m_valid}, 32'd0);
    bus.m_ready = 1'b1;
    i = 0;
    while (i < 40 && (busy || fifo_q.size() != 0)) begin step(); i++; end
    chk("fl_fifo_empty", fifo_q.size(), 0);
    repeat (10) step();
    chk("fl_done_once", n_fd, 1);
    chk("fl_no_more", n_hs, 2);
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk_cnt("cnt_after_flush");

    // reset mid-stream: full buffer plus a read issued in the reset cycle
    clr_counts();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 6; k++) push(8'h60 + k[DW-1:0]);
    repeat (8) step();
    chk("mr_valid", {31'd0, bus.m_valid}, 32'd1);
    bus.m_ready = 1'b1;
    reset = 1'b1;
    step();
    chk("mr_re", {31'd0, bus.Read_enable}, 32'd0);
    chk("mr_valid0", {31'd0, bus.m_valid}, 32'd0);
    chk("mr_data0", {24'd0, bus.m_data}, 32'd0);
    chk("mr_busy0", {31'd0, busy}, 32'd0);
    chk("mr_fdone0", {31'd0, flush_done}, 32'd0);
    chk_cnt("cnt_after_reset");
    chk("mr_fifo_left", fifo_q.size(), 3);
    reset = 1'b0;
    clr_counts();
    drain("mr", 40);
    chk("mr_hs", n_hs, 3);

    // randomized traffic
    clr_counts();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 32) push(DW'($urandom));
      bus.m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand", 200);
    chk_cnt("cnt_after_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side master for the team FIFO: pops words using Read_enable/empty/data_out and presents them downstream on a valid/ready stream.
- Absorbs the FIFO's 1-cycle registered read latency with a 2-entry output buffer, so throughput is one word per clock under continuous m_ready.
- Sits between the FIFO read port and any consumer. Also provides a flush sequence that discards buffered and queued data.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- ADDR_WIDTH, 5, FIFO address width; sets the width of the optional counter.
- BUF_DEPTH, 2, output buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- empty  input  1  FIFO empty flag.
- data_out  input  DATA_WIDTH  FIFO read data, valid the cycle after a Read_enable pop.
- Read_enable  output  1  FIFO pop request.
- m_valid  output  1  stream data valid.
- m_data  output  DATA_WIDTH  stream data.
- m_ready  input  1  consumer accept.
- flush  input  1  single-cycle pulse; requests discard of all pending data.
- busy  output  1  high when not in IDLE.
- flush_done  output  1  one-cycle pulse at end of a flush.

Behaviour:
- Reset: clk and reset as above; reset is synchronous and active-high.
  - Outputs: Read_enable=0, m_valid=0, m_data=0, busy=0, flush_done=0.
  - Internal state: occ=0, inflight=0, state=IDLE.
- Internal state:
  - occ (0..2): buffered words.
  - inflight (0/1): a pop was issued last cycle.
  - pop = m_valid && m_ready.
- Stream side:
  - m_valid = (occ != 0). m_data is the oldest buffered word.
  - m_data holds stable while m_valid && !m_ready.
- Read issue in STREAM: Read_enable = !empty && (occ + inflight < BUF_DEPTH + pop).
  - This never overruns the buffer.
  - It allows a sustained 1 word/cycle with occ=1, inflight=1.
- Capture: in the cycle after Read_enable, data_out is written to the buffer tail; inflight clears unless re-issued.
- Ordering: strict FIFO order; no word is duplicated or dropped outside a flush.
- Simultaneous capture and pop in the same cycle: occ is unchanged and the order is preserved.
- FSM states:
  - IDLE:
    - !empty moves to STREAM.
    - flush moves to FLUSH.
  - STREAM:
    - Goes to IDLE when empty && occ==0 && inflight==0 && !flush.
    - flush moves to FLUSH.
  - FLUSH:
    - Read_enable = !empty. Captured words are discarded; occ is forced to 0 and m_valid=0.
    - Exits to IDLE when empty && inflight==0; flush_done pulses that cycle.
- busy = (state != IDLE).
- Words already presented before flush are dropped even if m_valid was high; no handshake completes in the flush cycle.
- flush asserted while already in FLUSH is ignored.
- Reset mid-operation: everything clears next edge. An in-flight data_out arriving after reset is ignored.
- Never issue Read_enable while empty=1.

Optional Feature:
- Macro FIFO_STREAM_READER_CNT_EN.
- When defined: adds output word_cnt, ADDR_WIDTH+1 bits, reset 0.
  - Increments on each pop; wraps modulo 2^(ADDR_WIDTH+1).
  - Not cleared by flush.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_stream_pkg holds:
  - State enum rd_state_t {IDLE, STREAM, FLUSH}.
  - Constant BUF_DEPTH=2.
  - Default DATA_WIDTH/ADDR_WIDTH.
- One sub-module, fifo_stream_skid_buf: 2-entry buffer with push/pop/clear, occ output and head data.
- The top holds the FSM, read-issue logic and inflight tracking.

Test Plan:
- Basic order: push 0x11,0x22,0x33 into FIFO, m_ready=1 → m_data 0x11,0x22,0x33 on consecutive cycles; Read_enable count=3; returns to IDLE, busy=0.
- Throughput: 32 words 0x00..0x1F, m_ready=1 → after 2-cycle startup, m_valid high 32 consecutive cycles; no Read_enable when empty=1.
- Backpressure: 5 words, m_ready=0 for 10 cycles → exactly 2 pops, occ=2, m_data=first word stable; release → remaining 3 delivered in order.
- Alternating m_ready 1/0 with 8 words 0xA0..0xA7 → all 8 delivered in order, no loss or duplicate.
- Flush: 10 words queued, accept 2, pulse flush → m_valid=0 next cycle, FIFO drained to empty, flush_done pulses once, no further stream data.
- Reset mid-stream with occ=2, inflight=1 → next cycle all outputs 0, state IDLE; with the macro defined, word_cnt=0.
